spi_reg_bank: RTL and testbench

Parametrised SPI register-file peripheral, successor to the write-only SPI configuration block. It sits between the chip's SPI pins and the output-enable/PWM control logic. It synchronises the SPI inputs into the system clock domain, decodes fixed-length write frames into a register bank of configurable size and width, and adds SPI mode-0 read-back on `cipo`. It rejects malformed frames instead of committing them.

---
 rtl/spi_reg_bank.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 register file peripheral.
// The SPI pins are synchronised into clk, edges are detected on the
// synchronised copies, and fixed-length frames {R/W, addr, data} (MSB first)
// are decoded into a register bank. Read frames shift the addressed register
// out on cipo. Malformed frames (short or overrun) are discarded and flagged.
//
// Output handshake: wr_strobe and frame_err are single-cycle valid pulses
// with no ready/back-pressure; a consumer must take them in the cycle they
// are high. regs_flat already holds the new value in the strobe cycle.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err,
  output logic [2:0]                   dbg_state_o
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  // Cycles to wait after reset before trusting the synchronised ncs level.
  localparam int SETTLE  = SYNC_STAGES + 2;
  localparam int CNT_MAX = (FRAME_W > SETTLE) ? FRAME_W : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE     = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_SAT        = CNT_W'(CNT_MAX);

  typedef enum logic [2:0] {
    ST_WAIT_HI = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CMD     = 3'd2,
    ST_WR      = 3'd3,
    ST_RD      = 3'd4,
    ST_FULL    = 3'd5
  } state_t;

  // Synchroniser chains and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic                   sclk_dly_q;
  logic                   ncs_dly_q;
  logic                   copi_q;
  logic                   sclk_rise_q;
  logic                   sclk_fall_q;
  logic                   ncs_rise_q;
  logic                   ncs_fall_q;

  // Frame engine state
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc_d;
  logic [FRAME_W-1:0]     rx_q;
  logic [FRAME_W-1:0]     rx_shift_d;
  logic [DATA_W-1:0]      tx_q;
  logic [DATA_W-1:0]      snap_d;
  logic                   ovr_q;
  logic                   cipo_q;
  logic                   cipo_oe_q;
  logic [NUM_REGS-1:0]    wr_strobe_q;
  logic                   frame_err_q;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [ADDR_W-1:0]      frame_addr;

  // Pins enter through the synchroniser; edges are registered one stage later
  // so that copi_q is aligned with the sclk edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
      copi_q      <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      ncs_rise_q  <= 1'b0;
      ncs_fall_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
      copi_q      <= copi_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
      sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_dly_q;
      ncs_rise_q  <= ncs_sync_q[SYNC_STAGES-1] & ~ncs_dly_q;
      ncs_fall_q  <= ~ncs_sync_q[SYNC_STAGES-1] & ncs_dly_q;
    end
  end

  // Next shift value, saturating counter increment and the address field of a complete frame
  assign rx_shift_d = {rx_q[FRAME_W-2:0], copi_q};
  assign cnt_inc_d  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign frame_addr = rx_q[FRAME_W-2:DATA_W];

  // Read snapshot: addressed register, or zero when the address is out of range
  always_comb begin
    snap_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(rx_shift_d[ADDR_W-1:0]) == $unsigned(k)) snap_d = regs_q[k];
    end
  end

  // Frame FSM: shifts bits, drives cipo, commits or rejects on ncs rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_HI;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      ovr_q       <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      // An ncs rise takes priority over any sclk edge seen in the same cycle.
      if (ncs_rise_q && (state_q inside {ST_CMD, ST_WR, ST_RD, ST_FULL})) begin
        if (state_q == ST_FULL && !ovr_q) begin
          // Complete frame: writes to a matching address commit; reads and
          // out-of-range writes end quietly. Full-width compare, so no aliasing.
          if (rx_q[FRAME_W-1]) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (32'(frame_addr) == $unsigned(k)) begin
                regs_q[k]      <= rx_q[DATA_W-1:0];
                wr_strobe_q[k] <= 1'b1;
              end
            end
          end
        end else begin
          frame_err_q <= 1'b1;
        end
        state_q   <= ST_IDLE;
        cipo_q    <= 1'b0;
        cipo_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ST_WAIT_HI: begin
            // Let the synchroniser flush its reset values before looking at ncs.
            if (cnt_q != CNT_SETTLE) begin
              cnt_q <= cnt_inc_d;
            end else if (ncs_dly_q) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
          ST_IDLE: begin
            if (ncs_fall_q) begin
              state_q <= ST_CMD;
              cnt_q   <= '0;
              rx_q    <= '0;
              ovr_q   <= 1'b0;
            end
          end
          ST_CMD: begin
            if (sclk_rise_q) begin
              rx_q  <= rx_shift_d;
              cnt_q <= cnt_inc_d;
              if (cnt_q == CNT_CMD_LAST) begin
                if (rx_shift_d[ADDR_W]) begin
                  state_q <= ST_WR;
                end else begin
                  tx_q    <= snap_d;
                  state_q <= ST_RD;
                end
              end
            end
          end
          ST_WR: begin
            if (sclk_rise_q) begin
              rx_q  <= rx_shift_d;
              cnt_q <= cnt_inc_d;
              if (cnt_q == CNT_FRAME_LAST) state_q <= ST_FULL;
            end
          end
          ST_RD: begin
            // Rising edges count the frame; falling edges present the next bit.
            if (sclk_rise_q) begin
              cnt_q <= cnt_inc_d;
              if (cnt_q == CNT_FRAME_LAST) begin
                state_q   <= ST_FULL;
                cipo_q    <= 1'b0;
                cipo_oe_q <= 1'b0;
              end
            end else if (sclk_fall_q) begin
              cipo_q    <= tx_q[DATA_W-1];
              tx_q      <= tx_q << 1;
              cipo_oe_q <= 1'b1;
            end
          end
          ST_FULL: begin
            if (sclk_rise_q) ovr_q <= 1'b1;
          end
          default: state_q <= ST_WAIT_HI;
        endcase
      end
    end
  end

  // Flatten the register bank onto the output bus
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo        = cipo_q;
  assign cipo_oe     = cipo_oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign frame_err   = frame_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed frames against two instances (default parameters
// and a wide configuration). Expected events go into exp_q when stimulus is
// issued; a monitor pops and compares whenever a DUT strobes, flags an error
// or a read frame completes.
module tb_spi_reg_bank;

  localparam int A_NR = 5;
  localparam int A_AW = 7;
  localparam int A_DW = 8;
  localparam int A_SS = 2;
  localparam int B_NR = 16;
  localparam int B_AW = 4;
  localparam int B_DW = 16;
  localparam int B_SS = 3;
  localparam int EV_W = 71;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;
  localparam logic [1:0] K_RD  = 2'd3;

  logic clk;
  logic rst_n;
  logic sclk;
  logic copi;
  logic ncs_a;
  logic ncs_b;

  logic                   cipo_a, cipo_oe_a, frame_err_a;
  logic [A_NR*A_DW-1:0]   regs_a;
  logic [A_NR-1:0]        wstb_a;
  logic [2:0]             st_a;
  logic                   cipo_b, cipo_oe_b, frame_err_b;
  logic [B_NR*B_DW-1:0]   regs_b;
  logic [B_NR-1:0]        wstb_b;
  logic [2:0]             st_b;

  logic [EV_W-1:0] exp_q[$];
  logic [EV_W-1:0] obs_q[$];
  int checks;
  int passes;

  spi_reg_bank #(.NUM_REGS(A_NR), .ADDR_W(A_AW), .DATA_W(A_DW), .SYNC_STAGES(A_SS)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs_a), .copi(copi),
    .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_flat(regs_a), .wr_strobe(wstb_a),
    .frame_err(frame_err_a), .dbg_state_o(st_a)
  );

  spi_reg_bank #(.NUM_REGS(B_NR), .ADDR_W(B_AW), .DATA_W(B_DW), .SYNC_STAGES(B_SS)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs_b), .copi(copi),
    .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_flat(regs_b), .wr_strobe(wstb_b),
    .frame_err(frame_err_b), .dbg_state_o(st_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EV_W-1:0] mk_ev(input logic [1:0] kd, input logic d, input int a,
                                            input logic [31:0] dat, input logic [31:0] oe);
    return {kd, d, 4'(a), dat, oe};
  endfunction

  task automatic check_ev(input logic [EV_W-1:0] got, input string name);
    logic [EV_W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got event %h, expected none", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got === e) passes++;
      else $display("FAIL %s: got event %h, expected %h", name, got, e);
    end
  endtask

  task automatic check_val(input logic [319:0] got, input logic [319:0] exp, input string name);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_wr(input logic d, input int a, input logic [31:0] dat);
    exp_q.push_back(mk_ev(K_WR, d, a, dat, 32'h0));
  endtask

  task automatic exp_err(input logic d);
    exp_q.push_back(mk_ev(K_ERR, d, 0, 32'h0, 32'h0));
  endtask

  task automatic exp_rd(input logic d, input logic [31:0] dat, input logic [31:0] oe);
    exp_q.push_back(mk_ev(K_RD, d, 0, dat, oe));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check_val(320'({cipo_a, cipo_oe_a, frame_err_a, wstb_a, regs_a}), 320'(0), "rst_out_a");
      check_val(320'({cipo_b, cipo_oe_b, frame_err_b, wstb_b, regs_b}), 320'(0), "rst_out_b");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One frame on DUT d: fw-bit frame f, nbits clocks sent (extra bits are 0),
  // optional reset before bit rst_after, and for reads the captured cipo and
  // cipo_oe samples (taken at each sclk rise) are handed to the monitor.
  task automatic frame(input logic d, input logic [31:0] f, input int fw, input int nbits,
                       input int rst_after, input logic is_rd);
    int ph;
    logic [31:0] rd_bits;
    logic [31:0] oe_bits;
    ph = d ? (B_SS + 2) : (A_SS + 2);
    rd_bits = '0;
    oe_bits = '0;
    @(negedge clk);
    if (d) ncs_b = 1'b0; else ncs_a = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_after) do_reset(3);
      copi = (i < fw) ? f[fw-1-i] : 1'b0;
      wait_clks(ph);
      rd_bits = {rd_bits[30:0], d ? cipo_b : cipo_a};
      oe_bits = {oe_bits[30:0], d ? cipo_oe_b : cipo_oe_a};
      sclk = 1'b1;
      wait_clks(ph);
      sclk = 1'b0;
    end
    wait_clks(ph);
    if (d) ncs_b = 1'b1; else ncs_a = 1'b1;
    copi = 1'b0;
    if (is_rd) obs_q.push_back(mk_ev(K_RD, d, 0, rd_bits, oe_bits));
    wait_clks(12);
  endtask

  // Monitor: compares every strobe, error pulse and completed read
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < A_NR; k++)
        if (wstb_a[k] === 1'b1) check_ev(mk_ev(K_WR, 1'b0, k, 32'(regs_a[k*A_DW +: A_DW]), 32'h0), "wr_a");
      if (frame_err_a === 1'b1) check_ev(mk_ev(K_ERR, 1'b0, 0, 32'h0, 32'h0), "err_a");
      for (int k = 0; k < B_NR; k++)
        if (wstb_b[k] === 1'b1) check_ev(mk_ev(K_WR, 1'b1, k, 32'(regs_b[k*B_DW +: B_DW]), 32'h0), "wr_b");
      if (frame_err_b === 1'b1) check_ev(mk_ev(K_ERR, 1'b1, 0, 32'h0, 32'h0), "err_b");
      while (obs_q.size() > 0) check_ev(obs_q.pop_front(), "rd");
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d events outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    logic [255:0] exp_b;
    int t;
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    sclk   = 1'b0;
    copi   = 1'b0;
    ncs_a  = 1'b1;
    ncs_b  = 1'b1;
    do_reset(4);
    wait_clks(10);

    // Writes to reg 0 and reg 4
    exp_wr(1'b0, 0, 32'hA5);
    frame(1'b0, 32'h80A5, 16, 16, -1, 1'b0);
    exp_wr(1'b0, 4, 32'h3C);
    frame(1'b0, 32'h843C, 16, 16, -1, 1'b0);
    check_val(320'(regs_a), 320'(40'h3C_00_00_00_A5), "regs_a_wr");

    // Write reg 2 then read it back
    exp_wr(1'b0, 2, 32'h5A);
    frame(1'b0, 32'h825A, 16, 16, -1, 1'b0);
    exp_rd(1'b0, 32'h0000_005A, 32'h0000_00FF);
    frame(1'b0, 32'h0200, 16, 16, -1, 1'b1);
    check_val(320'(regs_a), 320'(40'h3C_00_5A_00_A5), "regs_a_rd");

    // Truncated and overrun writes to reg 1
    exp_err(1'b0);
    frame(1'b0, 32'h8177, 16, 12, -1, 1'b0);
    exp_err(1'b0);
    frame(1'b0, 32'h8177, 16, 17, -1, 1'b0);
    check_val(320'(regs_a), 320'(40'h3C_00_5A_00_A5), "regs_a_bad");

    // Out-of-range writes and read
    frame(1'b0, 32'h8511, 16, 16, -1, 1'b0);
    frame(1'b0, 32'hC522, 16, 16, -1, 1'b0);
    exp_rd(1'b0, 32'h0000_0000, 32'h0000_00FF);
    frame(1'b0, 32'h0500, 16, 16, -1, 1'b1);
    check_val(320'(regs_a), 320'(40'h3C_00_5A_00_A5), "regs_a_oor");

    // Reset after 6 bits, then a normal write
    frame(1'b0, 32'h8133, 16, 16, 6, 1'b0);
    check_val(320'(regs_a), 320'(0), "regs_a_rst");
    exp_wr(1'b0, 1, 32'h66);
    frame(1'b0, 32'h8166, 16, 16, -1, 1'b0);
    check_val(320'(regs_a), 320'(40'h00_00_00_66_00), "regs_a_after_rst");

    // Wide configuration: write and read back reg 15
    exp_wr(1'b1, 15, 32'hBEEF);
    frame(1'b1, 32'h1F_BEEF, 21, 21, -1, 1'b0);
    exp_rd(1'b1, 32'h0000_BEEF, 32'h0000_FFFF);
    frame(1'b1, 32'h0F_0000, 21, 21, -1, 1'b1);
    exp_b = 256'(16'hBEEF) << 240;
    check_val(320'(regs_b), 320'(exp_b), "regs_b");

    // Report
    t = 0;
    while ((exp_q.size() > 0 || obs_q.size() > 0) && t < 500) begin
      wait_clks(1);
      t++;
    end
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected events never seen", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
